// File: rtl/grid_seq.sv
// Solve sequencer for the node grid: resets the array, streams weights from the
// weight memory, clears the source node, then runs relaxation until quiet or timeout.
module grid_seq #(
    parameter int W       = 32,
    parameter int H       = 32,
    parameter int AW      = 10,
    parameter int XW      = 5,
    parameter int YW      = 5,
    parameter int QUIET   = 8,
    parameter int MAX_CYC = 65535,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [XW-1:0] src_x,
    input  logic [YW-1:0] src_y,
    input  logic          mod_any,
    output logic          wmem_rd,
    output logic [AW-1:0] wmem_addr,
    input  logic [3:0]    wmem_data,
    output logic          grid_rst,
    output logic          grid_ld,
    output logic [AW-1:0] grid_ld_addr,
    output logic [3:0]    grid_ld_weight,
    output logic          grid_clr,
    output logic [AW-1:0] grid_clr_addr,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic          src_blocked,
    output logic [CW-1:0] cycles
);

    localparam int N    = W * H;
    localparam int CNTW = AW + 1;
    localparam int QW   = $clog2(QUIET) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_LOAD,
        S_CLR,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state, state_n;
    logic [CNTW-1:0] cnt, cnt_n;
    logic [QW-1:0]   quiet_cnt, quiet_n;
    logic [AW-1:0]   src_idx, src_idx_n;
    logic            src_oor, src_oor_n;

    logic            rd_n, grst_n, ld_n, clr_n, busy_n, done_n, timeout_n, blocked_n;
    logic [AW-1:0]   addr_n, ld_addr_n, clr_addr_n;
    logic [CW-1:0]   cycles_n, cyc_inc;
    logic            ld_blk;

    assign grid_ld_weight = grid_ld ? wmem_data : 4'h0;

    // Every output is computed from the next state so it lines up with the state register.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        quiet_n    = quiet_cnt;
        src_idx_n  = src_idx;
        src_oor_n  = src_oor;
        timeout_n  = timeout;
        blocked_n  = src_blocked;
        cycles_n   = cycles;
        rd_n       = 1'b0;
        addr_n     = '0;
        grst_n     = 1'b0;
        ld_n       = 1'b0;
        ld_addr_n  = '0;
        clr_n      = 1'b0;
        clr_addr_n = '0;
        done_n     = 1'b0;
        ld_blk     = src_blocked | (grid_ld && (grid_ld_addr == src_idx) && (wmem_data == 4'hF));
        cyc_inc    = (cycles == CW'(MAX_CYC)) ? cycles : cycles + 1'b1;

        if (abort && state != S_IDLE) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_n   = S_RST;
                        grst_n    = 1'b1;
                        src_idx_n = AW'(32'(src_y) * 32'(W) + 32'(src_x));
                        src_oor_n = (32'(src_x) >= 32'(W)) || (32'(src_y) >= 32'(H));
                        timeout_n = 1'b0;
                        blocked_n = 1'b0;
                        cycles_n  = '0;
                    end
                end
                S_RST: begin
                    state_n = S_LOAD;
                    cnt_n   = '0;
                    rd_n    = 1'b1;
                    addr_n  = '0;
                end
                S_LOAD: begin
                    // Load strobe trails the read strobe by one cycle, matching memory latency.
                    ld_n      = wmem_rd;
                    ld_addr_n = wmem_addr;
                    blocked_n = ld_blk;
                    cnt_n     = cnt + 1'b1;
                    if (cnt == CNTW'(N)) begin
                        state_n   = S_CLR;
                        blocked_n = ld_blk | src_oor;
                        if (!(ld_blk | src_oor)) begin
                            clr_n      = 1'b1;
                            clr_addr_n = src_idx;
                        end
                    end else if ((cnt + 1'b1) < CNTW'(N)) begin
                        rd_n   = 1'b1;
                        addr_n = AW'(cnt + 1'b1);
                    end
                end
                S_CLR: begin
                    if (src_blocked) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = S_RUN;
                        quiet_n = '0;
                    end
                end
                S_RUN: begin
                    cycles_n = cyc_inc;
                    quiet_n  = mod_any ? '0 : quiet_cnt + 1'b1;
                    if (!mod_any && quiet_cnt == QW'(QUIET - 1)) begin
                        state_n = S_DONE;
                        done_n  = 1'b1;
                    end else if (cyc_inc == CW'(MAX_CYC)) begin
                        state_n   = S_DONE;
                        timeout_n = 1'b1;
                        done_n    = 1'b1;
                    end
                end
                S_DONE: state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end

        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            quiet_cnt     <= '0;
            src_idx       <= '0;
            src_oor       <= 1'b0;
            wmem_rd       <= 1'b0;
            wmem_addr     <= '0;
            grid_rst      <= 1'b0;
            grid_ld       <= 1'b0;
            grid_ld_addr  <= '0;
            grid_clr      <= 1'b0;
            grid_clr_addr <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            src_blocked   <= 1'b0;
            cycles        <= '0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            quiet_cnt     <= quiet_n;
            src_idx       <= src_idx_n;
            src_oor       <= src_oor_n;
            wmem_rd       <= rd_n;
            wmem_addr     <= addr_n;
            grid_rst      <= grst_n;
            grid_ld       <= ld_n;
            grid_ld_addr  <= ld_addr_n;
            grid_clr      <= clr_n;
            grid_clr_addr <= clr_addr_n;
            busy          <= busy_n;
            done          <= done_n;
            timeout       <= timeout_n;
            src_blocked   <= blocked_n;
            cycles        <= cycles_n;
        end
    end

endmodule
